// File: rtl/if_prefetch.sv
// Fetch/prefetch stage: issues 1-cycle-latency word fetches and buffers {pc, word} in a DEPTH-entry FIFO.
// Latency: request N -> instr_valid N+2. Fetching stalls while buffered + in-flight work would overflow the FIFO.
module if_prefetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  output logic [2:0]  instr_class,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          outstanding_q, outstanding_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];
  logic [31:0]   word_mem_d [DEPTH];

  logic          pop;
  logic          push;
  logic [OW-1:0] occupancy;

  always_comb begin
    instr_valid = (count_q != '0);
    pop         = instr_valid & instr_ready;
    // A response landing in a redirect cycle belongs to the old stream, so flush wins over push.
    push        = imem_rvalid & outstanding_q & ~kill_q & ~redirect_valid;
    occupancy   = OW'(count_q) + OW'(outstanding_q) - OW'(pop);
    imem_req    = reset & ~redirect_valid & (occupancy < DEPTH_W);
    imem_addr   = fetch_pc_q;
    instr_code  = instr_valid ? word_mem_q[rd_ptr_q] : 32'h0;
    instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  end

  always_comb begin
    instr_class = 3'd7;
    case (instr_code[6:0])
      7'b0110011:             instr_class = 3'd0;
      7'b0010011, 7'b0000011: instr_class = 3'd1;
      7'b0100011:             instr_class = 3'd2;
      7'b1100011:             instr_class = 3'd3;
      default:                instr_class = 3'd7;
    endcase
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = imem_req;
    kill_d        = 1'b0;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pc_mem_d      = pc_mem_q;
    word_mem_d    = word_mem_q;

    if (imem_req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      pc_mem_d[wr_ptr_q]   = req_pc_q;
      word_mem_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      kill_d     = outstanding_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= 32'h0;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= 32'h0;
        word_mem_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pc_mem_q      <= pc_mem_d;
      word_mem_q    <= word_mem_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random ready/redirect/reset traffic,
// checked against a queue-level model of the fetch stage and an in-order PC scoreboard.
module tb_if_prefetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic [2:0]  instr_class;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer = 0;

  logic        mem_req_q = 1'b0;
  logic [31:0] mem_addr_q = 32'h0;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_code(instr_code), .instr_pc(instr_pc), .instr_class(instr_class),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: remembers the request seen at each edge and answers one cycle later.
  always @(posedge clk) begin
    mem_req_q  <= imem_req;
    mem_addr_q <= imem_addr;
  end

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h0010_0113;
      32'h08: return 32'h0020_81B3;
      32'h0C: return 32'h0020_A023;
      32'h10: return 32'h0020_8463;
      32'h14: return 32'h0000_006F;
      default: begin
        h = a * 32'h9E37_79B1 + 32'h1234_5677;
        case (h[31:29])
          3'd0: opc = 7'b0110011;
          3'd1: opc = 7'b0010011;
          3'd2: opc = 7'b0000011;
          3'd3: opc = 7'b0100011;
          3'd4: opc = 7'b1100011;
          3'd5: opc = 7'b1101111;
          3'd6: opc = 7'b0110111;
          default: opc = 7'b1110011;
        endcase
        return {h[24:0], opc};
      end
    endcase
  endfunction

  function automatic logic [2:0] cls(input logic [31:0] w);
    case (w[6:0])
      7'b0110011:             return 3'd0;
      7'b0010011, 7'b0000011: return 3'd1;
      7'b0100011:             return 3'd2;
      7'b1100011:             return 3'd3;
      default:                return 3'd7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic stale);
    @(negedge clk);
    reset          = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rvalid    = mem_req_q | stale;
    imem_rdata     = imem_rvalid ? rom(mem_addr_q) : $urandom;
    #1;
  endtask

  // Reference model: FIFO contents as queues, one in-flight slot, kill flag, fetch PC.
  logic [31:0] m_pc[$];
  logic [31:0] m_word[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  bit          m_kill = 1'b0;
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] sb_next = 32'h0;
  bit          started = 1'b0;
  bit          m_valid, m_pop, m_req;
  logic [31:0] m_hpc, m_hword;
  int          m_occ;

  initial forever begin
    @(negedge clk);
    #2;
    if (started) begin
      m_valid = (m_pc.size() > 0);
      m_hpc   = m_valid ? m_pc[0] : 32'h0;
      m_hword = m_valid ? m_word[0] : 32'h0;
      m_pop   = m_valid && instr_ready;
      m_occ   = m_pc.size() + int'(m_infl) - int'(m_pop);
      m_req   = reset && !redirect_valid && (m_occ < DEPTH);
      chk("model_req", imem_req, m_req);
      chk("model_addr", imem_addr, m_fpc);
      chk("model_valid", instr_valid, m_valid);
      chk("model_pc", instr_pc, m_hpc);
      chk("model_code", instr_code, m_hword);
      chk("model_class", instr_class, m_valid ? cls(m_hword) : 3'd7);
      if (reset && instr_valid && instr_ready) begin
        chk("order_pc", instr_pc, sb_next);
        chk("order_word", instr_code, rom(instr_pc));
        sb_next = sb_next + 32'd4;
        n_xfer++;
      end
    end
    if (!reset) begin
      m_pc.delete();
      m_word.delete();
      m_infl  = 1'b0;
      m_kill  = 1'b0;
      m_fpc   = RESET_PC;
      sb_next = RESET_PC;
      started = 1'b1;
    end else if (started) begin
      if (redirect_valid) begin
        m_pc.delete();
        m_word.delete();
        m_fpc   = redirect_pc & ~32'd3;
        m_kill  = m_infl;
        m_infl  = 1'b0;
        sb_next = m_fpc;
      end else begin
        if (m_pop) begin
          void'(m_pc.pop_front());
          void'(m_word.pop_front());
        end
        if (imem_rvalid && m_infl && !m_kill) begin
          m_pc.push_back(m_infl_pc);
          m_word.push_back(imem_rdata);
        end
        m_kill = 1'b0;
        m_infl = m_req;
        if (m_req) begin
          m_infl_pc = m_fpc;
          m_fpc     = m_fpc + 32'd4;
        end
      end
    end
  end

  logic [31:0] code_tab [6] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3,
                                32'h0020_A023, 32'h0020_8463, 32'h0000_006F};
  logic [2:0]  cls_tab  [6] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd7};
  logic        prev_r = 1'b1;
  logic        prev_rv = 1'b0;
  logic        r_r, r_rdy, r_rv, r_st;
  logic [31:0] r_t;

  initial begin
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_code", instr_code, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_class", instr_class, 7);

    // Release reset; a spurious response in this first cycle must be ignored.
    drive(1, 1, 0, 0, 1);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RESET_PC);
    drive(1, 1, 0, 0, 0);
    chk("fill_valid", instr_valid, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0);
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, 32'(i * 4));
      if (i < 6) begin
        chk("stream_code", instr_code, code_tab[i]);
        chk("stream_class", instr_class, cls_tab[i]);
      end
    end

    // Backpressure: FIFO fills with 0x20/0x24 and fetching stops.
    for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 0);
    chk("bp_valid", instr_valid, 1);
    chk("bp_req", imem_req, 0);
    chk("bp_head", instr_pc, 32'h20);
    drive(1, 1, 0, 0, 0);
    chk("bp_release_req", imem_req, 1);
    chk("bp_release_addr", imem_addr, 32'h28);
    chk("bp_release_pc", instr_pc, 32'h20);
    drive(1, 1, 0, 0, 0);
    chk("bp_next_pc", instr_pc, 32'h24);
    drive(1, 1, 0, 0, 0);
    chk("bp_no_bubble", instr_pc, 32'h28);

    // Redirect while the 0x30 response is in flight.
    drive(1, 1, 1, 32'h40, 0);
    chk("redir_no_req", imem_req, 0);
    chk("redir_pop_pc", instr_pc, 32'h2C);
    drive(1, 1, 0, 0, 0);
    chk("redir_r1_valid", instr_valid, 0);
    chk("redir_r1_req", imem_req, 1);
    chk("redir_r1_addr", imem_addr, 32'h40);
    drive(1, 1, 0, 0, 0);
    chk("redir_r2_valid", instr_valid, 0);
    drive(1, 1, 0, 0, 0);
    chk("redir_r3_valid", instr_valid, 1);
    chk("redir_r3_pc", instr_pc, 32'h40);

    // Unaligned redirect target.
    drive(1, 1, 1, 32'h43, 0);
    drive(1, 1, 0, 0, 0);
    chk("align_addr", imem_addr, 32'h40);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("align_pc", instr_pc, 32'h40);

    // PC wrap at the top of the address space.
    drive(1, 1, 1, 32'hFFFF_FFF9, 0);
    drive(1, 1, 0, 0, 0);
    chk("wrap_first_addr", imem_addr, 32'hFFFF_FFF8);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    chk("wrap_addr", imem_addr, 32'h0);
    drive(1, 1, 0, 0, 0);
    chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0);
    chk("wrap_pc2", instr_pc, 32'h0);

    // One-cycle reset mid-stream.
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("mid_rst_req", imem_req, 0);
    drive(1, 1, 0, 0, 1);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", instr_pc, 0);
    chk("mid_rst_code", instr_code, 0);
    chk("mid_rst_class", instr_class, 7);
    chk("mid_rst_req1", imem_req, 1);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    drive(1, 1, 0, 0, 0);
    chk("mid_rst_stale", instr_valid, 0);
    drive(1, 1, 0, 0, 0);
    chk("mid_rst_first_valid", instr_valid, 1);
    chk("mid_rst_first_pc", instr_pc, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      r_r   = ($urandom_range(0, 99) != 0);
      r_st  = r_r && !prev_r;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = r_r && (($urandom_range(0, 15) == 0) || (prev_rv && $urandom_range(0, 3) == 0));
      case ($urandom_range(0, 2))
        0:       r_t = $urandom;
        1:       r_t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: r_t = 32'($urandom_range(0, 255));
      endcase
      prev_r  = r_r;
      prev_rv = r_rv;
      drive(r_r, r_rdy, r_rv, r_t, r_st);
    end
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("xfer_progress", 32'(n_xfer > 500), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction fetch and prefetch stage for the RV32I single-cycle core. It owns the fetch PC and issues word requests to the instruction memory, which has a fixed 1-cycle latency. Returned words are buffered with their PCs in a small FIFO and presented to the core on a valid/ready handshake, tagged with a coarse instruction class. Branch and jump redirects from the core flush the buffer and discard any response still in flight.

## Interface
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  word-aligned fetch address, valid when imem_req=1
- imem_rvalid  in  1  response valid, exactly 1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core accepts head
- instr_code  out  32  head instruction word
- instr_pc  out  32  head PC
- instr_class  out  3  0=R, 1=I (ALU-imm or load), 2=S, 3=B, 7=unknown; decoded from instr_code[6:0]
- redirect_valid  in  1  core requests a fetch restart
- redirect_pc  in  32  restart address; bits [1:0] forced to 0

## Operation
- State:
  - fetch_pc (32 bits)
  - FIFO of {pc, word} with count 0..DEPTH
  - outstanding (1 bit)
  - kill (1 bit)
- pop = instr_valid & instr_ready.
- Issue rule: imem_req = !redirect_valid & (count + outstanding − pop < DEPTH).
  - imem_addr = fetch_pc.
  - On issue, fetch_pc += 4 and outstanding is set for the next cycle.
- Response handling: when imem_rvalid=1 and kill=0, push {addr of that request, imem_rdata}.
  - The PC travels in a 1-deep register alongside outstanding.
  - When kill=1, drop the response.
- Push and pop in the same cycle leave count unchanged; the FIFO may never overflow.
- FIFO pointers wrap modulo DEPTH.
- Redirect, taking effect at the clock edge:
  - FIFO flushed (count=0).
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - kill = outstanding, so the in-flight response is discarded.
  - No request is issued in the redirect cycle.
- A pop in the redirect cycle is a completed transfer. The flush still discards all other entries.
- Redirect during the kill cycle: kill is re-evaluated from outstanding, which is 0 because no request was issued in the redirect cycle.
- instr_class is combinational from the head word:
  - 0110011 → 0
  - 0010011 / 0000011 → 1
  - 0100011 → 2
  - 1100011 → 3
  - otherwise 7
- instr_code, instr_pc and instr_class are 0 when instr_valid=0.
- Arithmetic: PC addition is 32-bit and wraps 32'hFFFF_FFFC → 0.

## Timing
- reset=0 at an edge clears everything:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr_code=0, instr_pc=0, instr_class=7
  - count=0, outstanding=0, kill=0
  - fetch_pc=RESET_PC
- Reset mid-operation discards the FIFO and in-flight data. A response arriving in the cycle after reset deasserts is ignored.
- First cycle with reset=1: imem_req=1, imem_addr=RESET_PC.
- Latency: request in cycle N, rvalid in N+1, instr_valid=1 in N+2.
- Steady state with instr_ready held 1: one instruction per cycle after the 2-cycle fill.
- Backpressure:
  - With instr_ready=0, the FIFO fills to DEPTH and imem_req drops to 0.
  - imem_req reasserts in the same cycle instr_ready returns to 1.
- Redirect asserted in cycle R:
  - instr_valid=0 in R+1.
  - Request for the new PC issued in R+1.
  - First new instruction valid in R+3.

## Test plan
1. Reset release with ROM words 0x00500093 at 0x0, 0x00100113 at 0x4, ready=1 → instr_valid rises 2 cycles after release. Outputs instr_pc=0x0 / instr_code=0x00500093 / class=1, then 0x4 / 0x00100113 / class=1 on consecutive cycles.
2. Stream 8 words with ready=1 → 8 consecutive transfers, PCs 0x0..0x1C, no bubbles after fill.
3. Hold ready=0 for 6 cycles, then 1 → count saturates at 2 and imem_req=0 while full. On release, PC order is preserved with no duplicates or losses.
4. Redirect to 0x40 while a request for 0x8 is in flight → the 0x8 word never appears. Next output is pc=0x40 exactly 3 cycles after the redirect cycle.
5. Redirect to 0x43 → fetch address is 0x40.
6. Pull reset low mid-stream for 1 cycle, then release → all outputs return to their reset values. Fetch restarts at RESET_PC, and the stale response is not pushed.
7. Classify 0x002081B3, 0x0020A023, 0x00208463, 0x0000006F → class values 0, 2, 3, 7 respectively.
